// File: rtl/mem_responder.sv
// mem_responder -- single-port word RAM behind a valid/ready request channel.
//
// Serves RV32I-style loads and stores (B/H/W, BU/HU for loads) one at a time.
// A request is accepted in IDLE, waits WAIT_CYCLES cycles and completes with a
// single-cycle registered response pulse.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words in the RAM (power of two, >= 2)
//   WAIT_CYCLES  extra cycles between acceptance and response (0..15)
//
// Ports
//   clk         clock, all state changes on its rising edge
//   reset       asynchronous active-high reset (RAM contents are kept)
//   req_valid   request present
//   req_ready   responder idle and able to accept
//   req_write   1 = store, 0 = load
//   req_addr    byte address
//   req_funct3  RV32I size/sign code
//   req_wdata   store data, valid bytes right-aligned
//   resp_valid  one-cycle completion pulse
//   resp_rdata  extended load data, 0 for stores and errors
//   resp_error  failed access (qualified by resp_valid)
//
// Configuration macro
//   MEM_ALIGN_CHECK_EN  when defined, misaligned H/W accesses are errors and
//                       never write; otherwise the low address bits are
//                       forced to the natural alignment.

module mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_error_q, resp_error_d;

  // Latched request (data path, no reset needed)
  logic        write_q;
  logic [31:0] addr_q;
  logic [2:0]  funct3_q;
  logic [31:0] wdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        cur_write;
  logic [31:0] cur_addr;
  logic [2:0]  cur_f3;
  logic [31:0] cur_wdata;
  logic [1:0]  cur_off;
  logic [AW-1:0] cur_idx;
  logic        cur_err;
  logic        f3_ok, range_err, misalign, is_half, is_word;
  logic        enter_respond;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wd;
  logic [31:0] rd_word;

  // Sign/zero extension of the selected byte or half of a read word.
  function automatic logic [31:0] load_extend(input logic [31:0] w,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*off +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  load_extend = {{24{b[7]}}, b};
      3'b001:  load_extend = {{16{h[15]}}, h};
      3'b100:  load_extend = {24'd0, b};
      3'b101:  load_extend = {16'd0, h};
      default: load_extend = w;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3,
                                          input logic [1:0] off);
    case (f3[1:0])
      2'b00:   store_be = 4'b0001 << off;
      2'b01:   store_be = 4'b0011 << off;
      default: store_be = 4'b1111;
    endcase
  endfunction

  // Replicating the right-aligned data across lanes lets the byte enables
  // pick the correct copy without a barrel shift.
  function automatic logic [31:0] store_data(input logic [2:0]  f3,
                                             input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   store_data = {4{wd[7:0]}};
      2'b01:   store_data = {2{wd[15:0]}};
      default: store_data = wd;
    endcase
  endfunction

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid & req_ready;

  // In IDLE the live request is decoded so a zero-wait store can commit on
  // its acceptance edge; otherwise the latched copy is used.
  assign cur_write = (state_q == IDLE) ? req_write  : write_q;
  assign cur_addr  = (state_q == IDLE) ? req_addr   : addr_q;
  assign cur_f3    = (state_q == IDLE) ? req_funct3 : funct3_q;
  assign cur_wdata = (state_q == IDLE) ? req_wdata  : wdata_q;
  assign cur_idx   = cur_addr[AW+1:2];

  always_comb begin
    case (cur_f3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = ~cur_write;
      default:                f3_ok = 1'b0;
    endcase
    range_err = (cur_addr >> (AW + 2)) != 32'd0;
    is_half   = (cur_f3[1:0] == 2'b01);
    is_word   = (cur_f3[1:0] == 2'b10);
`ifdef MEM_ALIGN_CHECK_EN
    misalign  = (is_half & cur_addr[0]) | (is_word & (cur_addr[1:0] != 2'b00));
    cur_off   = cur_addr[1:0];
`else
    misalign  = 1'b0;
    if (is_word)      cur_off = 2'b00;
    else if (is_half) cur_off = {cur_addr[1], 1'b0};
    else              cur_off = cur_addr[1:0];
`endif
    cur_err = ~f3_ok | range_err | misalign;
  end

  assign rd_word       = mem[cur_idx];
  assign enter_respond = (state_d == RESPOND) && (state_q != RESPOND);
  assign mem_we        = enter_respond & cur_write & ~cur_err;
  assign mem_be        = store_be(cur_f3, cur_off);
  assign mem_wd        = store_data(cur_f3, cur_wdata);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'd0;
    resp_error_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_d = RESPOND;
            cnt_d   = 4'd0;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = RESPOND;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESPOND: begin
        state_d      = IDLE;
        resp_valid_d = 1'b1;
        resp_error_d = cur_err;
        if (!cur_err && !cur_write)
          resp_rdata_d = load_extend(rd_word, cur_f3, cur_off);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      write_q  <= req_write;
      addr_q   <= req_addr;
      funct3_q <= req_funct3;
      wdata_q  <= req_wdata;
    end
  end

  // RAM is never reset or initialised; lanes outside the enable keep their value.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem[cur_idx][8*b +: 8] <= mem_wd[8*b +: 8];
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_error = resp_error_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, the number of 32-bit words in the internal RAM (power of two).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, the extra cycles between acceptance and response (0..15).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on posedge clk.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  the initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  the responder can accept a request this cycle.
REQ-007 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  the byte address.
REQ-009 SHALL have port req_funct3  input  3  the RV32I size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 SHALL have port req_wdata  input  32  the store data, with the valid bytes right-aligned.
REQ-011 SHALL have port resp_valid  output  1  a one-cycle pulse marking completion.
REQ-012 SHALL have port resp_rdata  output  32  the load result, already extended; 0 for stores and errors.
REQ-013 SHALL have port resp_error  output  1  qualified by resp_valid; marks a failed access.

Function
REQ-014 SHALL implement an FSM with states IDLE, WAIT, RESPOND.
REQ-015 SHALL drive req_ready=1 only in IDLE.
REQ-016 SHALL accept a request on a posedge where req_valid & req_ready, latching write, addr, funct3 and wdata.
REQ-017 SHALL, on acceptance, go IDLE->WAIT with the wait counter loaded to WAIT_CYCLES; if WAIT_CYCLES=0, SHALL go IDLE->RESPOND directly.
REQ-018 SHALL, in WAIT, decrement the counter each cycle and go to RESPOND when the counter reaches 1 (total latency acceptance-to-resp_valid = WAIT_CYCLES+1 cycles).
REQ-019 SHALL assert resp_valid for exactly one cycle in RESPOND, then return to IDLE; resp_valid, resp_rdata and resp_error SHALL be registered outputs.
REQ-020 SHALL ignore req_valid while not in IDLE; back-to-back requests are served one per (WAIT_CYCLES+2) cycles.
REQ-021 SHALL perform a load by reading the word at addr[31:2], selecting the byte/half by addr[1:0], and sign-extending (B, H) or zero-extending (BU, HU).
REQ-022 SHALL perform a store as a byte-enable write on the entering-RESPOND edge: SB writes 1 lane, SH writes 2 lanes, SW writes 4 lanes; the other lanes SHALL be unchanged.
REQ-023 SHALL flag resp_error=1 when the word index is >= DEPTH_WORDS, or funct3 is not one of the five listed codes (011, 110, 111; for stores, 100 and 101 as well).
REQ-024 SHALL NOT write memory on an errored store.
REQ-025 SHALL complete an errored access with the normal latency and resp_rdata=0.
REQ-026 SHALL leave memory contents undefined at power-up, with no initialization inside the block.

Reset
REQ-027 SHALL, on reset assertion at any time, force IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0 and wait counter=0.
REQ-028 SHALL abandon an accepted but incomplete store on reset, with no write and no response.
REQ-029 SHALL NOT clear RAM contents on reset.

Configuration
REQ-030 SHALL, with macro MEM_ALIGN_CHECK_EN defined, flag resp_error=1 on misaligned accesses (H/HU with addr[0]=1; W with addr[1:0]!=0) and SHALL NOT write memory for them.
REQ-031 SHALL, without MEM_ALIGN_CHECK_EN, treat misaligned accesses as aligned by forcing addr[0]=0 for halves and addr[1:0]=0 for words, with no error.

Verification
REQ-032 SHALL cover: WAIT_CYCLES=1, SW 0xDEADBEEF at 0x10 then LW 0x10 -> resp_valid 2 cycles after each acceptance, rdata=0xDEADBEEF, error=0.
REQ-033 SHALL cover: after REQ-032, SB 0x5A at 0x11 then LW 0x10 -> 0xDEAD5AEF; LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD.
REQ-034 SHALL cover: LW at byte address DEPTH_WORDS*4 -> resp_error=1, rdata=0; a re-read of word 0 is unchanged.
REQ-035 SHALL cover: with MEM_ALIGN_CHECK_EN, SH at 0x21 -> error=1, no write; without it, the same SH writes 0x20..0x21, error=0.
REQ-036 SHALL cover: reset asserted during WAIT of SW 0x1 at 0x30 -> no resp_valid, req_ready=1 immediately, a later LW 0x30 returns the prior value.
REQ-037 SHALL cover: req_valid held high across 3 requests with WAIT_CYCLES=0 -> acceptances exactly every 2 cycles, 3 resp_valid pulses.
